ahb_master_seq: RTL

AHB-Lite master sequencer for the FPGA slave pair: accepts one command (single or burst, read or write) from the board-level control logic and drives the shared address/control/write-data bus and the per-slave selects. It runs the pipelined address/data phases and honours wait states from the selected slave's `hreadyout`. It terminates on ERROR responses and returns read data beat by beat. It sits between the switch/confirm front end and the two `ahbslave` instances, replacing manual bus driving.

---
 rtl/ahb_pkg.sv | 37 +++
 rtl/ahb_addr_gen.sv | 21 ++
 rtl/ahb_master_seq.sv | 158 +++++++++++++++
 3 files changed

// File: rtl/ahb_pkg.sv
// Shared AHB-Lite definitions for the master sequencer.
// Holds the transfer/burst/response encodings, the sequencer state codes
// and a helper that maps an hburst code to its beat count.
package ahb_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HBURST_SINGLE = 3'b000;
  localparam logic [2:0] HBURST_INCR   = 3'b001;
  localparam logic [2:0] HBURST_WRAP4  = 3'b010;
  localparam logic [2:0] HBURST_INCR4  = 3'b011;
  localparam logic [2:0] HBURST_WRAP8  = 3'b100;
  localparam logic [2:0] HBURST_INCR8  = 3'b101;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_ADDR  = 3'd1;
  localparam state_t ST_BURST = 3'd2;
  localparam state_t ST_LAST  = 3'd3;
  localparam state_t ST_ERR   = 3'd4;

  // Unsupported codes collapse to a single beat.
  function automatic logic [3:0] burst_beats(input logic [2:0] burst);
    case (burst)
      HBURST_WRAP4, HBURST_INCR4: burst_beats = 4'd4;
      HBURST_INCR8:               burst_beats = 4'd8;
      default:                    burst_beats = 4'd1;
    endcase
  endfunction

endpackage

// File: rtl/ahb_addr_gen.sv
// Next-address generator for the master sequencer.
//   addr  : current address phase address
//   wrap  : 1 for WRAP4 (only bits [1:0] advance), 0 for INCR
//   nxt   : address of the following beat
// The top bit is the slave select and is never modified, so an INCR burst
// wraps inside its own slave's window instead of crossing into the other.
module ahb_addr_gen #(
  parameter int ADDR_W = 10
) (
  input  logic [ADDR_W-1:0] addr,
  input  logic              wrap,
  output logic [ADDR_W-1:0] nxt
);

  always_comb begin
    nxt = addr;
    if (wrap) nxt[1:0] = addr[1:0] + 2'd1;
    else      nxt[ADDR_W-2:0] = addr[ADDR_W-2:0] + {{(ADDR_W-2){1'b0}}, 1'b1};
  end

endmodule

// File: rtl/ahb_master_seq.sv
// AHB-Lite master sequencer for the two-slave FPGA bus.
// Accepts one command (single/WRAP4/INCR4/INCR8, read or write), drives the
// shared address/control/write-data bus and the slave selects, honours wait
// states, aborts on ERROR and returns read data one beat at a time.
//   hclk/hreset             : clock, async active-high reset
//   cmd_*                   : command handshake (ready only in IDLE)
//   wd_data/wd_pop          : first-word-fall-through write data source
//   rd_data/rd_valid        : read beat strobe
//   done/err                : end-of-command strobe, err qualifies abort
//   haddr..hwdata, hsel_*   : master bus outputs
//   hreadyout_*/hresp_*/hrdata_* : slave responses
module ahb_master_seq
  import ahb_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
) (
  input  logic              hclk,
  input  logic              hreset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [2:0]        cmd_burst,
  input  logic [DATA_W-1:0] wd_data,
  output logic              wd_pop,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              err,
  output logic [ADDR_W-1:0] haddr,
  output logic              hwrite,
  output logic [2:0]        hburst,
  output logic [1:0]        htrans,
  output logic [DATA_W-1:0] hwdata,
  output logic              hsel_1,
  output logic              hsel_2,
  input  logic              hreadyout_1,
  input  logic              hresp_1,
  input  logic [DATA_W-1:0] hrdata_1,
  input  logic              hreadyout_2,
  input  logic              hresp_2,
  input  logic [DATA_W-1:0] hrdata_2
);

  state_t            state;
  logic              sel;        // 0 = slave 1, 1 = slave 2
  logic              dpend;      // a data phase is outstanding on the bus
  logic              dwrite;     // direction of the outstanding data phase
  logic [3:0]        beats_left; // address phases still to issue after the current one
  logic [ADDR_W-1:0] addr_nxt;
  logic              hready_s, hresp_s;
  logic [DATA_W-1:0] hrdata_s;
  logic              addr_ok, err_first;
  logic [3:0]        cmd_beats;

  ahb_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
    .addr (haddr),
    .wrap (hburst == HBURST_WRAP4),
    .nxt  (addr_nxt)
  );

  // With no data phase pending the bus is treated as ready.
  always_comb begin
    hready_s = 1'b1;
    hresp_s  = HRESP_OKAY;
    hrdata_s = sel ? hrdata_2 : hrdata_1;
    if (dpend) begin
      hready_s = sel ? hreadyout_2 : hreadyout_1;
      hresp_s  = sel ? hresp_2 : hresp_1;
    end
  end

  assign cmd_ready = (state == ST_IDLE);
  assign cmd_beats = burst_beats(cmd_burst);
  assign addr_ok   = hready_s && (htrans != HTRANS_IDLE);
  // Only writes draw from the write-data source; reads must not drain it.
  assign wd_pop    = addr_ok && hwrite;
  assign err_first = dpend && (hresp_s == HRESP_ERROR) && !hready_s;
  assign hsel_1    = (state != ST_IDLE) && !sel;
  assign hsel_2    = (state != ST_IDLE) && sel;

  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state      <= ST_IDLE;
      sel        <= 1'b0;
      dpend      <= 1'b0;
      dwrite     <= 1'b0;
      beats_left <= '0;
      haddr      <= '0;
      hwrite     <= 1'b0;
      hburst     <= HBURST_SINGLE;
      htrans     <= HTRANS_IDLE;
      hwdata     <= '0;
      rd_data    <= '0;
      rd_valid   <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      rd_valid <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            state      <= ST_ADDR;
            sel        <= cmd_addr[ADDR_W-1];
            haddr      <= cmd_addr;
            hwrite     <= cmd_write;
            hburst     <= (cmd_beats == 4'd1) ? HBURST_SINGLE : cmd_burst;
            htrans     <= HTRANS_NONSEQ;
            beats_left <= cmd_beats - 4'd1;
          end
        end
        ST_ADDR, ST_BURST, ST_LAST: begin
          if (err_first) begin
            // Cancel whatever address phase is on the bus.
            htrans <= HTRANS_IDLE;
            state  <= ST_ERR;
          end else if (hready_s) begin
            if (dpend && !dwrite && (hresp_s == HRESP_OKAY)) begin
              rd_valid <= 1'b1;
              rd_data  <= hrdata_s;
            end
            if (state == ST_LAST) begin
              done  <= 1'b1;
              dpend <= 1'b0;
              state <= ST_IDLE;
            end else begin
              dpend  <= 1'b1;
              dwrite <= hwrite;
              if (hwrite) hwdata <= wd_data;
              if (beats_left == 4'd0) begin
                htrans <= HTRANS_IDLE;
                state  <= ST_LAST;
              end else begin
                htrans     <= HTRANS_SEQ;
                haddr      <= addr_nxt;
                beats_left <= beats_left - 4'd1;
                state      <= ST_BURST;
              end
            end
          end
        end
        ST_ERR: begin
          if (hready_s) begin
            done  <= 1'b1;
            err   <= 1'b1;
            dpend <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
